seq_frame_tx: RTL
=================

Name: seq_frame_tx

Overview:
- Serial frame transmitter; the transmit end of the 1-bit sync-word link whose receive end is the overlapping sequence detector.
- Accepts a parallel word over a valid/ready handshake and shifts one bit per clock onto data_out.
- Frame format: sync word, payload MSB first, optional even-parity bit, then idle zeros.
- Sits between the payload source and the serial line feeding the detector.

Parameters:
- SYNC_PAT, 5'b10110, sync word; transmitted MSB first.
- SYNC_LEN, 5, width of SYNC_PAT in bits (1..8).
- DATA_W, 8, payload width in bits (1..16).
- PARITY_EN, 1, 1 = append an even-parity bit after the payload; 0 = omit it.
- GAP, 2, number of forced-0 idle cycles after each frame (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- tx_data  in  DATA_W  payload word; sampled only on the acceptance edge.
- tx_valid  in  1  source has a word to send.
- tx_ready  out  1  block can accept a word; tx_ready = (state==IDLE) && !rst.
- data_out  out  1  serial line; registered.
- tx_busy  out  1  high whenever state != IDLE; registered.
- frame_done  out  1  one-cycle pulse in the final cycle of each frame.

Behaviour:
- Reset: rst high at an edge forces the following after that edge:
  - state=IDLE, data_out=0, tx_busy=0, frame_done=0;
  - shift register and counters cleared.
  - Reset applies in every state, including mid-frame; the partial frame is abandoned with no frame_done.
  - tx_ready is 0 while rst is high; tx_valid is ignored during reset.
- Acceptance: at an edge where tx_valid && tx_ready, tx_data is latched into a shift register.
  - Edge T means the acceptance edge. Later changes on tx_data do not affect the frame.
- FSM states: IDLE -> SYNC -> DATA -> PARITY (skipped if PARITY_EN=0) -> GAP (skipped if GAP=0) -> IDLE.
- IDLE: data_out=0, tx_busy=0. On acceptance go to SYNC.
- SYNC: SYNC_LEN cycles, driving SYNC_PAT bits MSB first. Cycle T+1 carries SYNC_PAT[SYNC_LEN-1].
- DATA: DATA_W cycles, driving tx_data[DATA_W-1] down to tx_data[0].
- PARITY: 1 cycle, driving the XOR of all payload bits, so total payload+parity ones count is even.
- GAP: GAP cycles with data_out=0.
- Return to IDLE after the last frame cycle.
- Frame length L = SYNC_LEN + DATA_W + PARITY_EN + GAP cycles, occupying T+1 .. T+L.
- frame_done is high exactly in cycle T+L.
- tx_ready returns high at T+L+1, so the earliest next acceptance is edge T+L+1.
  - Consecutive frames are therefore separated by at least one IDLE cycle (data_out=0).
- tx_busy is high for cycles T+1 .. T+L.
- No back-pressure on the serial side. No payload filtering: the source is responsible for payload bits that reproduce SYNC_PAT.
- Counter width: enough to hold max(SYNC_LEN, DATA_W, GAP). Counters count down and reload on each state entry.
- tx_valid held high continuously: a new word is accepted every L+1 cycles.

Test Plan:
- Defaults, tx_data=8'hA5 accepted at T:
  - data_out T+1..T+16 = 1,0,1,1,0, 1,0,1,0,0,1,0,1, 0, 0,0;
  - frame_done only at T+16; tx_ready high again at T+17.
- Defaults, tx_data=8'h07: parity bit at T+14 = 1; tx_busy high T+1..T+16, low at T+17.
- tx_valid held high with words 8'h01 then 8'hFF:
  - second acceptance at edge T+17; second sync begins at T+18;
  - data_out=0 at T+17.
- rst asserted at T+8 (mid-DATA):
  - from T+9, data_out=0, tx_busy=0, tx_ready low until rst drops;
  - no frame_done; next frame starts with a full sync word.
- PARITY_EN=0, GAP=0, DATA_W=4, tx_data=4'hC:
  - data_out T+1..T+9 = 1,0,1,1,0,1,1,0,0;
  - frame_done at T+9; tx_ready at T+10.
- tx_data changed on the cycle after acceptance: the transmitted payload equals the value at edge T; tx_valid while busy is not accepted.

Source files
------------

// File: rtl/seq_frame_tx.sv
// seq_frame_tx
// Serial frame transmitter for the 1-bit sync-word link. A parallel word is
// taken over a valid/ready handshake and sent one bit per clock as:
//   sync word (MSB first) | payload (MSB first) | even parity (optional) | idle zeros
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous, active-high reset
//   tx_data     payload word, sampled only on the acceptance edge
//   tx_valid    source has a word to send
//   tx_ready    block can accept a word (IDLE and not in reset)
//   data_out    serial line, registered
//   tx_busy     high while a frame is on the line, registered
//   frame_done  one-cycle pulse in the final cycle of each frame, registered
//
// FSM states
//   state    | meaning
//   S_IDLE   | line held at 0, waiting for tx_valid
//   S_SYNC   | shifting out SYNC_PAT, SYNC_LEN cycles
//   S_DATA   | shifting out the latched payload, DATA_W cycles
//   S_PARITY | one cycle carrying the XOR of the payload bits
//   S_GAP    | GAP forced-zero cycles before returning to idle
//
// All outputs are registered, so every branch below loads the value the line
// must carry in the cycle that follows the edge. The down-counter holds the
// number of cycles still to come in the current state after this one; a
// terminal count of zero means the state ends at the next edge.

module seq_frame_tx #(
    parameter int                  SYNC_LEN  = 5,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT  = 5'b10110,
    parameter int                  DATA_W    = 8,
    parameter int                  PARITY_EN = 1,
    parameter int                  GAP       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              data_out,
    output logic              tx_busy,
    output logic              frame_done
);

    localparam int MAX_SD  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int MAX_CNT = (MAX_SD > GAP) ? MAX_SD : GAP;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    // The state that carries the last cycle of every frame; frame_done is
    // raised when that state is about to run its terminal-count cycle.
    localparam state_t LAST_ST = (GAP > 0)       ? S_GAP    :
                                 (PARITY_EN != 0) ? S_PARITY : S_DATA;

    state_t              state;
    state_t              state_after;
    logic [CNT_W-1:0]    cnt;
    logic [SYNC_LEN-1:0] sync_sr;
    logic [DATA_W-1:0]   data_sr;
    logic                par_bit;

    // Successor of each frame state, with the optional states skipped.
    function automatic state_t next_after(input state_t st);
        state_t nxt;
        nxt = S_IDLE;
        case (st)
            S_SYNC: nxt = S_DATA;
            S_DATA: begin
                if (PARITY_EN != 0) nxt = S_PARITY;
                else if (GAP > 0)   nxt = S_GAP;
                else                nxt = S_IDLE;
            end
            S_PARITY: nxt = (GAP > 0) ? S_GAP : S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

    // Counter load on state entry: cycles remaining after the entry cycle.
    function automatic logic [CNT_W-1:0] reload_of(input state_t st);
        logic [CNT_W-1:0] r;
        r = '0;
        case (st)
            S_SYNC:  r = CNT_W'(SYNC_LEN - 1);
            S_DATA:  r = CNT_W'(DATA_W - 1);
            S_GAP:   r = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign state_after = next_after(state);

    // Ready is combinational on rst so a word offered during reset is never
    // taken, even though the FSM itself only sees rst at the edge.
    assign tx_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sync_sr    <= '0;
            data_sr    <= '0;
            par_bit    <= 1'b0;
            data_out   <= 1'b0;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    frame_done <= 1'b0;
                    if (tx_valid) begin
                        // The sync MSB goes out in the first frame cycle, so
                        // the shift register is preloaded already advanced.
                        state    <= S_SYNC;
                        cnt      <= reload_of(S_SYNC);
                        sync_sr  <= SYNC_PAT << 1;
                        data_sr  <= tx_data;
                        par_bit  <= ^tx_data;
                        data_out <= SYNC_PAT[SYNC_LEN-1];
                        tx_busy  <= 1'b1;
                    end else begin
                        data_out <= 1'b0;
                        tx_busy  <= 1'b0;
                    end
                end

                default: begin
                    if (cnt != '0) begin
                        cnt        <= cnt - CNT_W'(1);
                        frame_done <= (state == LAST_ST) && (cnt == CNT_W'(1));
                        case (state)
                            S_SYNC: begin
                                data_out <= sync_sr[SYNC_LEN-1];
                                sync_sr  <= sync_sr << 1;
                            end
                            S_DATA: begin
                                data_out <= data_sr[DATA_W-1];
                                data_sr  <= data_sr << 1;
                            end
                            default: data_out <= 1'b0;
                        endcase
                    end else begin
                        state      <= state_after;
                        cnt        <= reload_of(state_after);
                        tx_busy    <= (state_after != S_IDLE);
                        frame_done <= (state_after == LAST_ST) &&
                                      (reload_of(state_after) == '0);
                        case (state_after)
                            S_DATA: begin
                                data_out <= data_sr[DATA_W-1];
                                data_sr  <= data_sr << 1;
                            end
                            S_PARITY: data_out <= par_bit;
                            default:  data_out <= 1'b0;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
